// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared types for the MIPS load/store unit:
//   op_e     - load/store operation encoding carried on req_op
//   state_e  - load/store unit FSM state encoding
//   is_store - true for SW/SH/SB
//   is_misaligned - alignment rule for word and halfword accesses
// ---------------------------------------------------------------------------
package mips_mem_pkg;

   typedef enum logic [2:0] {
      OP_LW  = 3'd0,
      OP_LH  = 3'd1,
      OP_LHU = 3'd2,
      OP_LB  = 3'd3,
      OP_LBU = 3'd4,
      OP_SW  = 3'd5,
      OP_SH  = 3'd6,
      OP_SB  = 3'd7
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_LOAD     = 3'd1,
      ST_RMW_READ = 3'd2,
      ST_WRITE    = 3'd3,
      ST_RESP     = 3'd4
   } state_e;

   function automatic logic is_store(op_e op);
      return (op == OP_SW) || (op == OP_SH) || (op == OP_SB);
   endfunction

   // Words must sit on a 4-byte boundary, halfwords on a 2-byte boundary;
   // byte accesses are always aligned.
   function automatic logic is_misaligned(op_e op, logic [1:0] lo);
      logic word_op;
      logic half_op;
      word_op = (op == OP_LW) || (op == OP_SW);
      half_op = (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
      return (word_op && (lo != 2'b00)) || (half_op && lo[0]);
   endfunction

endpackage

// File: rtl/mips_load_store_unit_if.sv
// ---------------------------------------------------------------------------
// mips_load_store_unit_if
// Bundles the request/response handshake and the data-memory port of the
// load/store unit.
//   slave  - the load/store unit: takes requests, returns responses,
//            drives the memory address/data/write strobe, reads mem_rdata.
//   master - the environment: pipeline stage issuing requests plus the data
//            memory supplying combinational read data.
// Signals: req_valid/req_ready/req_op/req_addr/req_wdata,
//          resp_valid/resp_data/resp_fault,
//          mem_addr/mem_wdata/mem_write/mem_rdata.
// ---------------------------------------------------------------------------
interface mips_load_store_unit_if;
   import mips_mem_pkg::*;

   logic        req_valid;
   logic        req_ready;
   op_e         req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;

   logic        resp_valid;
   logic [31:0] resp_data;
   logic        resp_fault;

   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_write;
   logic [31:0] mem_rdata;

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_data, resp_fault,
             mem_addr, mem_wdata, mem_write
   );

   modport master (
      output req_valid, req_op, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_data, resp_fault,
             mem_addr, mem_wdata, mem_write
   );

endinterface

// File: rtl/be_lane_unit.sv
// ---------------------------------------------------------------------------
// be_lane_unit
// Combinational big-endian lane handling for the load/store unit.
//   op          - current operation
//   lane        - byte offset within the word (addr[1:0])
//   word        - word read from memory
//   wdata       - low half of the store data (SH uses [15:0], SB uses [7:0])
//   load_data   - extracted lane, sign- or zero-extended for loads
//   merged_word - word with the store lane replaced (SH/SB), else word
// Byte offset k lives in bits [31-8k -: 8]; half offset 0 is [31:16].
// ---------------------------------------------------------------------------
module be_lane_unit
   import mips_mem_pkg::*;
(
   input  op_e         op,
   input  logic [1:0]  lane,
   input  logic [31:0] word,
   input  logic [15:0] wdata,
   output logic [31:0] load_data,
   output logic [31:0] merged_word
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // NOTE: every combinational output gets a default before the case so no
   // path leaves it unassigned, which would otherwise infer a latch.
   always_comb begin
      byte_sel = word[31:24];
      case (lane)
         2'd0: byte_sel = word[31:24];
         2'd1: byte_sel = word[23:16];
         2'd2: byte_sel = word[15:8];
         2'd3: byte_sel = word[7:0];
         default: byte_sel = word[31:24];
      endcase
      half_sel = lane[1] ? word[15:0] : word[31:16];

      load_data = word;
      case (op)
         OP_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
         OP_LBU:  load_data = {24'h0, byte_sel};
         OP_LH:   load_data = {{16{half_sel[15]}}, half_sel};
         OP_LHU:  load_data = {16'h0, half_sel};
         default: load_data = word;
      endcase

      merged_word = word;
      if (op == OP_SH) begin
         if (lane[1]) merged_word[15:0]  = wdata;
         else         merged_word[31:16] = wdata;
      end else if (op == OP_SB) begin
         case (lane)
            2'd0: merged_word[31:24] = wdata[7:0];
            2'd1: merged_word[23:16] = wdata[7:0];
            2'd2: merged_word[15:8]  = wdata[7:0];
            2'd3: merged_word[7:0]   = wdata[7:0];
            default: merged_word = word;
         endcase
      end
   end

endmodule

// File: rtl/mips_load_store_unit.sv
// ---------------------------------------------------------------------------
// mips_load_store_unit
// Data-memory initiator for the MIPS execute/memory stage. Takes one
// load/store request at a time, performs word and sub-word accesses on a
// word-wide big-endian memory without byte enables (sub-word stores use a
// read-modify-write), and rejects misaligned or out-of-range accesses with
// a fault response without touching memory.
//   clk, rst - clock and synchronous active-high reset
//   bus      - request/response handshake and memory port (slave modport)
// Parameter MEMORY_SIZE: memory size in bytes; last valid word address is
// MEMORY_SIZE-4.
// ---------------------------------------------------------------------------
module mips_load_store_unit
   import mips_mem_pkg::*;
#(
   parameter int unsigned MEMORY_SIZE = 64
) (
   input logic clk,
   input logic rst,
   mips_load_store_unit_if.slave bus
);

   localparam logic [31:0] LAST_WORD = 32'(MEMORY_SIZE - 4);

   state_e      state_q, state_d;
   op_e         op_q;
   logic [31:0] addr_q;
   logic [15:0] wdata_q;
   logic [31:0] merge_q;
   logic [31:0] resp_data_q;
   logic        resp_fault_q;

   logic        access_fault;
   logic [31:0] word_addr_q;
   logic [31:0] load_data;
   logic [31:0] merged_word;

   assign access_fault = is_misaligned(bus.req_op, bus.req_addr[1:0])
                       || ({bus.req_addr[31:2], 2'b00} > LAST_WORD);
   assign word_addr_q  = {addr_q[31:2], 2'b00};

   be_lane_unit u_lane (
      .op          (op_q),
      .lane        (addr_q[1:0]),
      .word        (bus.mem_rdata),
      .wdata       (wdata_q),
      .load_data   (load_data),
      .merged_word (merged_word)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the values from before the edge, independent of block order.
   always_ff @(posedge clk) begin
      if (rst) state_q <= ST_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d        = state_q;
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.mem_addr   = 32'h0;
      bus.mem_wdata  = 32'h0;
      bus.mem_write  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) begin
               if (access_fault)              state_d = ST_RESP;
               else if (bus.req_op == OP_SW)  state_d = ST_WRITE;
               else if (is_store(bus.req_op)) state_d = ST_RMW_READ;
               else                           state_d = ST_LOAD;
            end
         end
         ST_LOAD: begin
            bus.mem_addr = word_addr_q;
            state_d      = ST_RESP;
         end
         ST_RMW_READ: begin
            bus.mem_addr = word_addr_q;
            state_d      = ST_WRITE;
         end
         ST_WRITE: begin
            bus.mem_addr  = word_addr_q;
            bus.mem_wdata = merge_q;
            bus.mem_write = 1'b1;
            state_d       = ST_RESP;
         end
         ST_RESP: begin
            bus.resp_valid = 1'b1;
            state_d        = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Reset is synchronous, so the state register still holds the old
      // state during the reset cycle; silence every output immediately so a
      // pending write cannot reach memory in that cycle.
      if (rst) begin
         bus.req_ready  = 1'b0;
         bus.resp_valid = 1'b0;
         bus.mem_addr   = 32'h0;
         bus.mem_wdata  = 32'h0;
         bus.mem_write  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         op_q         <= OP_LW;
         addr_q       <= 32'h0;
         wdata_q      <= 16'h0;
         merge_q      <= 32'h0;
         resp_data_q  <= 32'h0;
         resp_fault_q <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (bus.req_valid) begin
                  op_q         <= bus.req_op;
                  addr_q       <= bus.req_addr;
                  wdata_q      <= bus.req_wdata[15:0];
                  // SW writes the store data unchanged; SH/SB overwrite this
                  // in RMW_READ.
                  merge_q      <= bus.req_wdata;
                  resp_data_q  <= 32'h0;
                  resp_fault_q <= access_fault;
               end
            end
            ST_LOAD:     resp_data_q <= load_data;
            ST_RMW_READ: merge_q     <= merged_word;
            default: ;
         endcase
      end
   end

   assign bus.resp_data  = resp_data_q;
   assign bus.resp_fault = resp_fault_q;

endmodule

// File: tb/tb_mips_load_store_unit.sv
// ---------------------------------------------------------------------------
// tb_mips_load_store_unit
// Directed scoreboard bench for mips_load_store_unit. The stimulus process
// pushes the expected response and expected memory write (with their cycle
// numbers) when a request is accepted; independent monitors on the falling
// edge pop and compare whenever resp_valid or mem_write is seen.
// ---------------------------------------------------------------------------
module tb_mips_load_store_unit;
   import mips_mem_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mips_load_store_unit_if bus ();

   mips_load_store_unit #(.MEMORY_SIZE(64)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   // Data memory model: 16 words, combinational read, write on posedge.
   logic [31:0] mem [16];
   logic        mem_init = 1'b1;

   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
         mem[0] <= 32'h11223344;
         mem[2] <= 32'h8899AABB;
      end else if (bus.mem_write && (bus.mem_addr < 32'd64)) begin
         mem[bus.mem_addr[5:2]] <= bus.mem_wdata;
      end
   end

   assign bus.mem_rdata = (bus.mem_addr < 32'd64) ? mem[bus.mem_addr[5:2]] : 32'h0;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [31:0] data;
      logic        fault;
      int          cyc;
      string       name;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
      int          cyc;
      string       name;
   } wr_t;

   resp_t resp_q[$];
   wr_t   wr_q[$];

   // Response monitor
   always @(negedge clk) begin
      if (bus.resp_valid) begin
         if (resp_q.size() == 0) begin
            check("spurious_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
         end else begin
            resp_t r;
            r = resp_q.pop_front();
            check({r.name, "_resp_data"},  bus.resp_data, r.data);
            check({r.name, "_resp_fault"}, {31'h0, bus.resp_fault}, {31'h0, r.fault});
            check({r.name, "_resp_cycle"}, 32'(cyc), 32'(r.cyc));
         end
      end
   end

   // Memory write monitor
   always @(negedge clk) begin
      if (bus.mem_write) begin
         if (wr_q.size() == 0) begin
            check("spurious_mem_write", {31'h0, bus.mem_write}, 32'h0);
         end else begin
            wr_t w;
            w = wr_q.pop_front();
            check({w.name, "_wr_addr"},  bus.mem_addr, w.addr);
            check({w.name, "_wr_data"},  bus.mem_wdata, w.data);
            check({w.name, "_wr_cycle"}, 32'(cyc), 32'(w.cyc));
         end
      end
   end

   // Present a request (called just after a falling edge) and wait for it to
   // be accepted. On return the clock sits at the falling edge one cycle
   // after acceptance and req_valid is still high.
   task automatic issue(input op_e op, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_data, input logic exp_fault, input int lat,
                        input bit exp_wr, input logic [31:0] wr_data, input int wr_lat,
                        input bit track, input string name, output int acc);
      int n;
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      n = 0;
      while (!bus.req_ready && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (!bus.req_ready) begin
         check({name, "_accept_timeout"}, {31'h0, bus.req_ready}, 32'h1);
         acc = -1;
         bus.req_valid = 1'b0;
         return;
      end
      acc = cyc;
      if (track) begin
         resp_q.push_back('{data: exp_data, fault: exp_fault, cyc: acc + lat, name: name});
         if (exp_wr)
            wr_q.push_back('{addr: {addr[31:2], 2'b00}, data: wr_data, cyc: acc + wr_lat, name: name});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain(input string name);
      int n;
      bus.req_valid = 1'b0;
      n = 0;
      while ((resp_q.size() != 0 || wr_q.size() != 0) && n < 20) begin
         @(negedge clk);
         n++;
      end
      check({name, "_drain_pending"}, 32'(resp_q.size() + wr_q.size()), 32'h0);
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

   initial begin
      int acc, acc2;
      bus.req_valid = 1'b0;
      bus.req_op    = OP_LW;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;

      repeat (3) @(negedge clk);
      mem_init = 1'b0;
      rst      = 1'b0;
      @(negedge clk);

      // Reset state
      check("rst_req_ready",  {31'h0, bus.req_ready}, 32'h1);
      check("rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      check("rst_resp_data",  bus.resp_data, 32'h0);
      check("rst_resp_fault", {31'h0, bus.resp_fault}, 32'h0);
      check("rst_mem_write",  {31'h0, bus.mem_write}, 32'h0);
      check("rst_mem_addr",   bus.mem_addr, 32'h0);
      check("rst_mem_wdata",  bus.mem_wdata, 32'h0);

      // Sub-word and word loads from word 8 = 0x8899AABB
      issue(OP_LB,  32'd9,  32'h0, 32'hFFFFFF99, 1'b0, 2, 1'b0, 32'h0, 0, 1'b1, "lb9", acc);   drain("lb9");
      issue(OP_LBU, 32'd9,  32'h0, 32'h00000099, 1'b0, 2, 1'b0, 32'h0, 0, 1'b1, "lbu9", acc);  drain("lbu9");
      issue(OP_LH,  32'd10, 32'h0, 32'hFFFFAABB, 1'b0, 2, 1'b0, 32'h0, 0, 1'b1, "lh10", acc);  drain("lh10");
      issue(OP_LHU, 32'd10, 32'h0, 32'h0000AABB, 1'b0, 2, 1'b0, 32'h0, 0, 1'b1, "lhu10", acc); drain("lhu10");
      issue(OP_LW,  32'd8,  32'h0, 32'h8899AABB, 1'b0, 2, 1'b0, 32'h0, 0, 1'b1, "lw8", acc);   drain("lw8");

      // Byte store via read-modify-write, then read back
      issue(OP_SB, 32'd11, 32'h12345677, 32'h0, 1'b0, 3, 1'b1, 32'h8899AA77, 2, 1'b1, "sb11", acc); drain("sb11");
      issue(OP_LW, 32'd8,  32'h0, 32'h8899AA77, 1'b0, 2, 1'b0, 32'h0, 0, 1'b1, "lw8_after_sb", acc); drain("lw8_after_sb");

      // Halfword store into a zero word, full-word store to the last word
      issue(OP_SH, 32'd12, 32'h0000BEEF, 32'h0, 1'b0, 3, 1'b1, 32'hBEEF0000, 2, 1'b1, "sh12", acc); drain("sh12");
      issue(OP_SW, 32'd60, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1'b1, 32'hDEADBEEF, 1, 1'b1, "sw60", acc); drain("sw60");
      issue(OP_LW, 32'd60, 32'h0, 32'hDEADBEEF, 1'b0, 2, 1'b0, 32'h0, 0, 1'b1, "lw60", acc); drain("lw60");
      issue(OP_LH, 32'd14, 32'h0, 32'h00000000, 1'b0, 2, 1'b0, 32'h0, 0, 1'b1, "lh14", acc); drain("lh14");
      issue(OP_LH, 32'd12, 32'h0, 32'hFFFFBEEF, 1'b0, 2, 1'b0, 32'h0, 0, 1'b1, "lh12", acc); drain("lh12");

      // Faults: response one cycle after accept, no memory write
      issue(OP_LW, 32'd6,         32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 0, 1'b1, "flt_lw6", acc);   drain("flt_lw6");
      issue(OP_LH, 32'd3,         32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 0, 1'b1, "flt_lh3", acc);   drain("flt_lh3");
      issue(OP_LW, 32'd64,        32'h0, 32'h0, 1'b1, 1, 1'b0, 32'h0, 0, 1'b1, "flt_lw64", acc);  drain("flt_lw64");
      issue(OP_SB, 32'hFFFFFFFF,  32'hAB, 32'h0, 1'b1, 1, 1'b0, 32'h0, 0, 1'b1, "flt_sbmax", acc); drain("flt_sbmax");

      // Reset while SH 0 is in RMW_READ: request is discarded
      issue(OP_SH, 32'd0, 32'h0000CAFE, 32'h0, 1'b0, 3, 1'b0, 32'h0, 0, 1'b0, "sh0_rst", acc);
      rst = 1'b1;
      bus.req_valid = 1'b0;
      check("sh0_rst_write_in_reset", {31'h0, bus.mem_write}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("sh0_rst_req_ready",  {31'h0, bus.req_ready}, 32'h1);
      check("sh0_rst_resp_valid", {31'h0, bus.resp_valid}, 32'h0);
      check("sh0_rst_mem_write",  {31'h0, bus.mem_write}, 32'h0);
      repeat (4) @(negedge clk);
      check("sh0_rst_word0", mem[0], 32'h11223344);

      // Held req_valid: LW 0 then LB 1 back to back
      issue(OP_LW, 32'd0, 32'h0, 32'h11223344, 1'b0, 2, 1'b0, 32'h0, 0, 1'b1, "held_lw0", acc);
      issue(OP_LB, 32'd1, 32'h0, 32'h00000022, 1'b0, 2, 1'b0, 32'h0, 0, 1'b1, "held_lb1", acc2);
      check("held_accept_gap", 32'(acc2 - acc), 32'd3);
      drain("held");

      repeat (3) @(negedge clk);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mips_load_store_unit.md
Name: mips_load_store_unit

Overview:
- Initiator side of the data-memory interface. Accepts load/store requests from the MIPS execute/memory stage and drives the word-wide, big-endian, byte-addressed data memory.
- Memory port: combinational word read; word write committed on the posedge when write is high; no byte enables.
- Implements sub-word loads (sign/zero extension) and sub-word stores (read-modify-write sequence).
- Detects misaligned and out-of-range accesses and returns a fault instead of touching memory.

Parameters:
- MEMORY_SIZE, 64, data memory size in bytes; valid word address range is 0..MEMORY_SIZE-4.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit can accept a request (IDLE only).
- req_op  in  3  operation: LW, LH, LHU, LB, LBU, SW, SH, SB.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data; low-order bits used for SH/SB.
- resp_valid  out  1  one-cycle response pulse.
- resp_data  out  32  load result; 0 for stores and faults.
- resp_fault  out  1  qualifies resp_valid; access rejected.
- mem_addr  out  32  word-aligned address to memory.
- mem_wdata  out  32  word to write.
- mem_write  out  1  write strobe.
- mem_rdata  in  32  combinational read data for mem_addr.

Behaviour:
- Reset: state=IDLE; resp_valid=0, resp_data=0, resp_fault=0, mem_write=0, mem_addr=0, mem_wdata=0; all latched request registers cleared.
  - Reset mid-operation discards the pending request; no memory write occurs in or after the reset cycle.
- FSM states: IDLE, LOAD, RMW_READ, WRITE, RESP.
- IDLE:
  - req_ready=1; mem_* outputs are 0.
  - On req_valid, latch op, addr and wdata, then check the access:
    - Misaligned: LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0 -> fault.
    - Out of range: {addr[31:2],2'b00} > MEMORY_SIZE-4, 32-bit unsigned compare -> fault.
  - Next state: fault -> RESP with fault flag set; loads -> LOAD; SW -> WRITE with merge register = wdata; SH/SB -> RMW_READ.
- LOAD: mem_addr = word address. Register the extracted lane into resp_data; -> RESP.
- RMW_READ: mem_addr = word address. Merge register = mem_rdata with the target lane replaced by wdata[15:0] or wdata[7:0]; -> WRITE.
- WRITE: mem_addr = word address, mem_wdata = merge register, mem_write=1 for exactly this cycle; -> RESP.
- RESP: resp_valid=1 for exactly one cycle; resp_fault and resp_data hold their latched values; -> IDLE. There is no response back-pressure.
- Latency from the accept cycle (cycle 0) to resp_valid:
  - Loads and SW: cycle 2.
  - SH/SB: cycle 3.
  - Faults: cycle 1.
- Throughput: one request in flight. req_ready is low from the cycle after accept through RESP; a held req_valid is accepted in the first IDLE cycle.
- Big-endian lanes:
  - Byte offset k occupies bits [31-8k -: 8].
  - Half offset 0 occupies [31:16]; half offset 2 occupies [15:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
- mem_write is never asserted outside WRITE and never asserted for a faulted request.

Decomposition:
- Package mips_mem_pkg holds:
  - the op encoding: LW=0, LH=1, LHU=2, LB=3, LBU=4, SW=5, SH=6, SB=7;
  - the FSM state encoding;
  - a helper function is_store(op).
- Sub-module be_lane_unit (combinational) implements big-endian lane extract+extend for loads and lane merge for stores. Inputs: op, addr[1:0], word, wdata. Outputs: load_data, merged_word.

Test Plan:
- Sub-word loads, memory word 8 preloaded with 0x8899AABB:
  - LB 9 -> resp_data 0xFFFFFF99 at cycle 2; LBU 9 -> 0x00000099.
  - LH 10 -> 0xFFFFAABB; LHU 10 -> 0x0000AABB.
  - LW 8 -> 0x8899AABB.
- SB 11 with wdata 0x12345677 (word 8 = 0x8899AABB):
  - exactly one mem_write, at cycle 2, mem_addr=8, mem_wdata=0x8899AA77;
  - resp_valid at cycle 3, resp_fault=0;
  - following LW 8 -> 0x8899AA77.
- SH 12 with wdata 0x0000BEEF (word 12 = 0):
  - mem_wdata=0xBEEF0000;
  - SW 60 with 0xDEADBEEF -> write at cycle 1, accepted (last valid word).
- Faults, each giving resp_valid & resp_fault at cycle 1 with resp_data=0 and mem_write never high:
  - LW 6 (misaligned);
  - LH 3 (misaligned);
  - LW 64 (out of range);
  - SB 0xFFFFFFFF (out of range).
- rst asserted during RMW_READ of SH 0:
  - no mem_write;
  - next cycle state IDLE, req_ready=1, resp_valid=0;
  - memory word 0 unchanged.
- req_valid held high with LW 0 then LB 1:
  - req_ready low for cycles 1-2;
  - second request accepted at cycle 3;
  - resp_valid pulses at cycles 2 and 5, each exactly one cycle wide.
